// File: rtl/sc_relu_sched.sv
// Round-robin scheduler sharing one saturating up/down-counter stochastic ReLU among NREQ bitstream requesters.
// Optional window abort on dropped request: define SC_RELU_SCHED_ABORT_EN.
module sc_relu_sched #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 5,
  parameter int LEN_W = 8,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  bit_in,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [NREQ-1:0]  grant,
  output logic             relu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ID_W-1:0]  res_id,
  output logic [LEN_W:0]   res_ones
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [DEPTH-1:0] MID = DEPTH'(1) << (DEPTH - 1);

  state_t           r_state;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_ptr;
  logic [DEPTH-1:0] r_cnt;
  logic [LEN_W:0]   r_rem;
  logic [LEN_W:0]   r_ones;
  logic             r_res_valid;

  logic             w_run;
  logic             w_abort;
  logic             w_live;
  logic             w_bit;
  logic             w_relu;
  logic [ID_W:0]    w_pick;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] rq,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0] res;
    int            j;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (rq[j]) res = {1'b1, ID_W'(j)};
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NREQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // Saturating up/down step: never wraps at either end.
  function automatic logic [DEPTH-1:0] sat_step(input logic [DEPTH-1:0] cnt,
                                                input logic b);
    logic [DEPTH-1:0] nxt;
    nxt = cnt;
    if (b && (cnt != '1))      nxt = cnt + DEPTH'(1);
    else if (!b && (cnt != '0)) nxt = cnt - DEPTH'(1);
    return nxt;
  endfunction

  assign w_run = (r_state == S_RUN);
`ifdef SC_RELU_SCHED_ABORT_EN
  assign w_abort = w_run & ~req[r_id];
`else
  assign w_abort = 1'b0;
`endif
  assign w_live = w_run & ~w_abort;
  assign w_bit  = bit_in[r_id];
  assign w_relu = w_live & r_cnt[DEPTH-1] & w_bit;
  assign w_pick = rr_pick(req, r_ptr);

  assign grant     = w_live ? (NREQ'(1) << r_id) : '0;
  assign relu_out  = w_relu;
  assign res_valid = r_res_valid;
  assign res_id    = r_id;
  assign res_ones  = r_ones;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_ptr       <= '0;
      r_cnt       <= MID;
      r_rem       <= '0;
      r_ones      <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick[ID_W]) begin
            r_id    <= w_pick[ID_W-1:0];
            r_rem   <= (cfg_len == '0) ? ((LEN_W + 1)'(1) << LEN_W) : {1'b0, cfg_len};
            r_cnt   <= MID;
            r_ones  <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_ptr   <= next_id(r_id);
            r_state <= S_IDLE;
          end else begin
            r_cnt  <= sat_step(r_cnt, w_bit);
            r_ones <= r_ones + (LEN_W + 1)'(w_relu);
            r_rem  <= r_rem - (LEN_W + 1)'(1);
            if (r_rem == (LEN_W + 1)'(1)) begin
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_ptr       <= next_id(r_id);
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_relu_sched.sv
// Self-checking bench for sc_relu_sched: directed and randomized windows against a behavioural model.
module tb_sc_relu_sched;
  localparam int NREQ  = 4;
  localparam int DEPTH = 5;
  localparam int LEN_W = 8;
  localparam int ID_W  = 2;
  localparam int MID   = 1 << (DEPTH - 1);
  localparam int CMAX  = (1 << DEPTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  bit_in;
  logic [LEN_W-1:0] cfg_len;
  logic [NREQ-1:0]  grant;
  logic             relu_out;
  logic             res_valid;
  logic             res_ready;
  logic [ID_W-1:0]  res_id;
  logic [LEN_W:0]   res_ones;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  sc_relu_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .cfg_len(cfg_len),
    .grant(grant), .relu_out(relu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_ones(res_ones)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] rq, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (rq[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int stim_bit(input int mode, input int i);
    case (mode)
      0:       return 1;
      1:       return 0;
      2:       return (i % 2 == 0) ? 1 : 0;
      3:       return (i % 2 == 1) ? 1 : 0;
      default: return int'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; bit_in = '0; cfg_len = '0; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_id", 32'(res_id), 32'h0);
    chk("rst_ones", 32'(res_ones), 32'h0);
    chk("rst_relu", 32'(relu_out), 32'h0);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Starts just after a negedge with the DUT idle; ends the same way one cycle after the handshake.
  task automatic window(input logic [NREQ-1:0] rv, input int len, input int mode, input int hold);
    int id, n, cnt, ones, b, er;
    logic [NREQ-1:0] v;
    id = pick(rv, m_ptr);
    req = rv;
    cfg_len = LEN_W'(len);
    res_ready = (hold == 0);
    n = (len == 0) ? (1 << LEN_W) : len;
    cnt = MID;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b = stim_bit(mode, i);
      v = NREQ'($urandom);
      v[id] = b[0];
      bit_in = v;
      cfg_len = LEN_W'($urandom);
      #1;
      er = (cnt >= MID && b == 1) ? 1 : 0;
      chk("run_grant", 32'(grant), 32'(1 << id));
      chk("run_relu", 32'(relu_out), 32'(er));
      chk("run_valid", 32'(res_valid), 32'h0);
      ones += er;
      if (b == 1) cnt = (cnt < CMAX) ? cnt + 1 : cnt;
      else        cnt = (cnt > 0) ? cnt - 1 : cnt;
    end
    @(negedge clk);
    bit_in = '1;
    #1;
    chk("done_valid", 32'(res_valid), 32'h1);
    chk("done_id", 32'(res_id), 32'(id));
    chk("done_ones", 32'(res_ones), 32'(ones));
    chk("done_grant", 32'(grant), 32'h0);
    chk("done_relu", 32'(relu_out), 32'h0);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      bit_in = NREQ'($urandom);
      #1;
      chk("stall_valid", 32'(res_valid), 32'h1);
      chk("stall_id", 32'(res_id), 32'(id));
      chk("stall_ones", 32'(res_ones), 32'(ones));
      chk("stall_grant", 32'(grant), 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("gap_valid", 32'(res_valid), 32'h0);
    chk("gap_grant", 32'(grant), 32'h0);
    m_ptr = (id + 1) % NREQ;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // No requests: nothing is granted.
    req = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_valid", 32'(res_valid), 32'h0);

    window(4'b0001, 8, 0, 0);
    window(4'b0001, 8, 1, 0);
    window(4'b0001, 8, 2, 0);
    window(4'b0001, 8, 3, 0);
    window(4'b0001, 20, 0, 0);
    window(4'b0001, 0, 0, 0);

    // Round-robin order from reset with 1011 held: 0,1,3,0.
    do_reset();
    window(4'b1011, 6, 4, 0);
    window(4'b1011, 5, 4, 0);
    window(4'b1011, 7, 4, 0);
    window(4'b1011, 4, 4, 0);

    // Result held while the consumer stalls.
    window(4'b0100, 6, 4, 5);

    // Reset mid-window discards it.
    req = 4'b0001;
    cfg_len = 8'd8;
    @(negedge clk);
    bit_in = '1;
    #1;
    chk("mr_grant0", 32'(grant), 32'h1);
    @(negedge clk);
    #1;
    chk("mr_grant1", 32'(grant), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_valid", 32'(res_valid), 32'h0);
    chk("mr_relu", 32'(relu_out), 32'h0);
    chk("mr_ones", 32'(res_ones), 32'h0);
    rst = 1'b0;
    req = '0;
    m_ptr = 0;
    @(negedge clk);
    #1;
    chk("mr_idle_valid", 32'(res_valid), 32'h0);
    window(4'b1010, 3, 0, 0);

`ifdef SC_RELU_SCHED_ABORT_EN
    do_reset();
    req = 4'b0011;
    cfg_len = 8'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_in = '1;
      if (i == 2) req = 4'b0010;
      #1;
      chk("ab_grant", 32'(grant), (i < 2) ? 32'h1 : 32'h0);
      if (i == 2) chk("ab_relu", 32'(relu_out), 32'h0);
    end
    @(negedge clk);
    #1;
    chk("ab_valid", 32'(res_valid), 32'h0);
    chk("ab_idle_grant", 32'(grant), 32'h0);
    m_ptr = 1;
    window(4'b0010, 8, 0, 0);
`endif

    // Randomized windows.
    for (int r = 0; r < 12; r++) begin
      window(NREQ'($urandom_range(1, 15)), int'($urandom_range(1, 40)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sc_relu_sched.md
Name: sc_relu_sched

Overview:
Round-robin scheduler that time-shares one stochastic ReLU evaluator among NREQ bitstream requesters. Each granted requester streams a window of cfg_len bits. The block runs the saturating up/down counter ReLU on that stream and emits the ReLU output bit live. At window end it reports the window's output ones-count through a valid/ready result port. It sits between the per-neuron SNG/bitstream sources and the layer accumulator.

Parameters:
NREQ, 4, number of requesters (>=2)
DEPTH, 5, ReLU counter width in bits; midpoint = 2^(DEPTH-1)
LEN_W, 8, width of cfg_len; result width is LEN_W+1
ID_W, 2, width of requester index (= clog2(NREQ))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  NREQ  level request per requester
bit_in  in  NREQ  stochastic input bit per requester
cfg_len  in  LEN_W  window length, sampled at grant; 0 means 2^LEN_W
grant  out  NREQ  one-hot; high on the granted requester during RUN
relu_out  out  1  live ReLU output bit, valid while any grant bit is high
res_valid  out  1  result available
res_ready  in  1  result accepted when res_valid & res_ready
res_id  out  ID_W  requester index of result
res_ones  out  LEN_W+1  count of relu_out ones over the window

Behaviour:
- Reset (rst=1 at edge): state=IDLE, grant=0, res_valid=0, res_id=0, res_ones=0, rr pointer=0, counter=midpoint. relu_out=0.
- States: IDLE, RUN, DONE.
- IDLE, any req set: winner = first set req at or after pointer, wrapping. Register id. Load rem=cfg_len (0 -> 2^LEN_W). Counter=midpoint, ones=0. Go RUN. Only one grant per IDLE cycle.
- RUN: grant[id]=1. Each cycle relu_out = cnt[DEPTH-1] & bit_in[id], using counter value before update.
- RUN counter update: bit=1 and cnt!=all-ones -> cnt+1; bit=0 and cnt!=0 -> cnt-1; otherwise hold (saturate both ends).
- RUN accounting: ones += relu_out; rem -= 1. When rem==1 this cycle, go DONE.
- Latency: request seen in IDLE at cycle t -> grant high cycles t+1..t+len -> res_valid from t+len+1.
- DONE: res_valid=1; res_id and res_ones stable until handshake. grant=0, relu_out=0. On res_valid & res_ready: pointer=id+1 (mod NREQ), go IDLE. No new grant in the handshake cycle.
- Counts never wrap: max ones = 2^LEN_W, which fits LEN_W+1 bits.
- Requester owns dropping req. If req[id] is still high when it returns to IDLE, it is a new request, subject to round-robin order.
- rst asserted in RUN or DONE: immediate return to reset values; the in-flight window and pending result are discarded.
- cfg_len and req of non-granted requesters are ignored outside the IDLE sampling cycle.

Optional Feature:
Macro SC_RELU_SCHED_ABORT_EN.
- Defined: if req[id] is 0 during RUN, that cycle is not counted. The window aborts: grant=0, no result produced, pointer=id+1, go IDLE next cycle.
- Undefined: req is ignored during RUN and the window always runs to full length.

Test Plan:
- DEPTH=5, len=8, req=0001, bit_in[0] all 1 -> grant[0] high 8 cycles, res_id=0, res_ones=8.
- len=8, bit_in[0] all 0 -> relu_out=0 every cycle, res_ones=0, counter ends at 8.
- len=8, alternating 1,0,... starting with 1 -> res_ones=4. Same stream starting with 0 -> res_ones=0.
- len=20, all 1 -> counter saturates at 31 and holds, res_ones=20. len=0, all 1 -> 256 grant cycles, res_ones=256.
- req=1011 held from reset, res_ready=1 -> grant order 0,1,3,0,...; each res_valid lasts 1 cycle; one IDLE cycle between windows.
- res_ready low 5 cycles in DONE -> res_valid, res_id and res_ones stable, grant=0. rst pulse mid-RUN -> next cycle grant=0 and res_valid=0. With ABORT_EN, req[0] dropped at cycle 3 of 8 -> no result, grant passes to the next requester.
